mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_acc_pkg.sv | 15 +
 rtl/mac_acc_pipe_reg.sv | 26 ++
 rtl/mac_accumulator.sv | 110 +++++++++++
 tb/tb_mac_accumulator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared state encodings and default widths for the MAC accumulator.
package mac_acc_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int LEN_W_DEF = 4;
  localparam int PROD_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_acc_pipe_reg.sv
// One-entry product stage sitting between the accept point and the adder.
// Only instantiated when MAC_ACC_PIPE_EN is defined.
module mac_acc_pipe_reg
  import mac_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [PROD_W-1:0] d,
  output logic [PROD_W-1:0] q,
  output logic              vld
);

  // Capture an accepted product for exactly one cycle; clear/reset empty it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= load;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Run-length multiply-accumulate sink: sums len_i+1 unsigned 8-bit products
// and presents the total until downstream takes it.
// Optional feature macro: MAC_ACC_PIPE_EN (registers each product before the
// adder, adding one DRAIN cycle of latency).
// Width rule: ACC_W must be >= 8 + LEN_W so the sum can never wrap.
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  output logic [ACC_W-1:0]  res_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              busy_o
);

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [LEN_W-1:0]    remaining;
  logic                accept, last;
  logic                add_en;
  logic [PROD_W-1:0]   add_val;

  assign accept = prod_valid_i && prod_ready_o;
  assign last   = accept && (remaining == '0);

`ifdef MAC_ACC_PIPE_EN
  logic [PROD_W-1:0] stg_q;
  logic              stg_vld;

  mac_acc_pipe_reg u_stg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_i),
    .load  (accept),
    .d     (prod_i),
    .q     (stg_q),
    .vld   (stg_vld)
  );

  assign add_en  = stg_vld;
  assign add_val = stg_q;
`else
  assign add_en  = accept;
  assign add_val = prod_i;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: clear aborts from anywhere; start only counts in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_ACCUM;
`ifdef MAC_ACC_PIPE_EN
      S_ACCUM: if (last) state_nxt = S_DRAIN;
`else
      S_ACCUM: if (last) state_nxt = S_DONE;
`endif
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (res_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear_i) state_nxt = S_IDLE;
  end

  // Outputs are pure functions of state; result is masked outside DONE.
  always_comb begin
    prod_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    res_o        = '0;
    busy_o       = (state != S_IDLE);
    case (state)
      S_ACCUM: prod_ready_o = 1'b1;
      S_DONE: begin
        res_valid_o = 1'b1;
        res_o       = acc;
      end
      default: ;
    endcase
  end

  // Accumulator and run counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      acc       <= '0;
      remaining <= '0;
    end else if (state == S_IDLE && start_i) begin
      acc       <= '0;
      remaining <= len_i;
    end else begin
      if (add_en) acc <= acc + ACC_W'(add_val);
      if (accept && remaining != '0) remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator.
module tb_mac_accumulator;

  localparam int ACC_W = 12;
  localparam int LEN_W = 4;
`ifdef MAC_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             clear_i;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic [7:0]       prod_i;
  logic             prod_valid_i;
  logic             prod_ready_o;
  logic [ACC_W-1:0] res_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic             busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;

  mac_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .prod_ready_o (prod_ready_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [LEN_W-1:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 1);
  endtask

  task automatic feed(input logic [7:0] p);
    int n = 0;
    prod_valid_i = 1'b1;
    prod_i       = p;
    while (!prod_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("feed_ready", 32'(prod_ready_o), 1);
    tick();
    prod_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (!res_valid_o && l < 10) begin
      tick();
      l++;
    end
  endtask

  task automatic finish_run();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_res", 32'(res_o), 0);
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    prod_i = '0; prod_valid_i = 1'b0; res_ready_i = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(prod_ready_o), 0);
    chk("rst_res", 32'(res_o), 0);
    chk("rst_valid", 32'(res_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    tick();

    // Four back-to-back products of 225.
    start_run(4'd3);
    for (int i = 0; i < 4; i++) feed(8'd225);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'(LAT));
    chk("b2b_res", 32'(res_o), 900);
    chk("b2b_valid", 32'(res_valid_o), 1);
    finish_run();

    // Full-length run of max products, then hold DONE with a stray product.
    start_run(4'd15);
    for (int i = 0; i < 16; i++) feed(8'd255);
    wait_done(lat);
    chk("max_res", 32'(res_o), 4080);
    prod_valid_i = 1'b1;
    prod_i       = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_res", 32'(res_o), 4080);
      chk("hold_ready", 32'(prod_ready_o), 0);
      chk("hold_valid", 32'(res_valid_o), 1);
    end
    prod_valid_i = 1'b0;
    finish_run();

    // Clear mid-run, then a single-product run.
    start_run(4'd3);
    feed(8'd100);
    feed(8'd50);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 0);
    chk("clr_res", 32'(res_o), 0);
    start_run(4'd0);
    feed(8'd7);
    wait_done(lat);
    chk("one_lat", 32'(lat), 32'(LAT));
    chk("one_res", 32'(res_o), 7);
    // start together with res_ready in DONE only returns to IDLE
    start_i = 1'b1; res_ready_i = 1'b1;
    tick();
    start_i = 1'b0; res_ready_i = 1'b0;
    chk("done_start_busy", 32'(busy_o), 0);
    tick();
    chk("done_start_idle", 32'(busy_o), 0);

    // clear beats start in IDLE
    clear_i = 1'b1; start_i = 1'b1;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    chk("clr_wins", 32'(busy_o), 0);

    // Gapped products with a stray start pulse mid-run.
    start_run(4'd2);
    feed(8'd10);
    for (int g = 0; g < 3; g++) begin
      start_i = (g == 1);
      len_i   = 4'd0;
      tick();
    end
    start_i = 1'b0;
    chk("gap_busy", 32'(busy_o), 1);
    feed(8'd20);
    repeat (3) tick();
    feed(8'd30);
    wait_done(lat);
    chk("gap_res", 32'(res_o), 60);
    finish_run();

    // Reset held two cycles mid-run, then a normal run.
    start_run(4'd3);
    feed(8'd50);
    rst_n = 1'b0;
    tick(); tick();
    chk("mrst_ready", 32'(prod_ready_o), 0);
    chk("mrst_res", 32'(res_o), 0);
    chk("mrst_valid", 32'(res_valid_o), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    tick();
    start_run(4'd1);
    feed(8'd3);
    feed(8'd4);
    wait_done(lat);
    chk("post_rst_res", 32'(res_o), 7);
    finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
